// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage: access-size encodings,
// burst length decode and the fetch FSM state type.
package fetch_pkg;

  localparam logic [1:0] ACCESS_1W  = 2'b00;
  localparam logic [1:0] ACCESS_4W  = 2'b01;
  localparam logic [1:0] ACCESS_8W  = 2'b10;
  localparam logic [1:0] ACCESS_16W = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    BURST,
    DRAIN
  } fetch_state_t;

  function automatic int unsigned burst_words(input logic [1:0] size);
    case (size)
      ACCESS_1W:  return 1;
      ACCESS_4W:  return 4;
      ACCESS_8W:  return 8;
      default:    return 16;
    endcase
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer of {pc, insn} entries with flush, occupancy and
// free-space outputs. Flush takes priority over a same-cycle push or pop.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count != '0);
    pop_data = mem[rd_ptr];
    free     = CW'(DEPTH) - count;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: burst-reads memory from the PC, buffers words with their PCs
// and hands them to decode. Optional misaligned-redirect trap: FETCH_ALIGN_CHECK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           FIFO_DEPTH   = 16,
  parameter logic [1:0]            BURST_SIZE   = 2'b01,
  parameter int unsigned           READ_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC     = 32'h8002_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [1:0]            mem_access_size,
  output logic                  mem_rw,
  output logic                  mem_enable,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [DATA_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] insn_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fetch_error
);

  localparam int unsigned BURST_WORDS = burst_words(BURST_SIZE);
  localparam int unsigned CW          = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BEAT_W      = 5;
  localparam int unsigned LAT_W       = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int unsigned ENTRY_W     = ADDR_WIDTH + DATA_WIDTH;

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [LAT_W-1:0]      lat_q;
  logic [BEAT_W-1:0]     beat_q;

  logic                  accept;
  logic                  beat_now;
  logic                  last_beat;
  logic                  redirect_ok;
  logic                  redirect_bad;
  logic [ADDR_WIDTH-1:0] redirect_target;
  logic                  halt;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [ENTRY_W-1:0]    fifo_push_data;
  logic [ENTRY_W-1:0]    fifo_pop_data;
  logic [CW-1:0]         fifo_count;
  logic [CW-1:0]         fifo_free;

`ifdef FETCH_ALIGN_CHECK_EN
  logic error_q;

  always_comb begin
    redirect_ok     = redirect_valid && (redirect_pc[1:0] == 2'b00);
    redirect_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    redirect_target = redirect_pc;
    halt            = error_q || redirect_bad;
    fetch_error     = error_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)             error_q <= 1'b0;
    else if (redirect_bad) error_q <= 1'b1;
  end
`else
  always_comb begin
    redirect_ok     = redirect_valid;
    redirect_bad    = 1'b0;
    redirect_target = redirect_pc & ~ADDR_WIDTH'(3);
    halt            = 1'b0;
    fetch_error     = 1'b0;
  end
`endif

  // Beats carry no strobe: the latency and beat counters alone say when mem_data is live.
  always_comb begin
    accept    = (state_q == REQ) && !mem_busy;
    beat_now  = (state_q inside {BURST, DRAIN}) && (lat_q == '0);
    last_beat = beat_now && (beat_q == BEAT_W'(BURST_WORDS - 1));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Space for a whole burst is reserved before issuing, so the buffer never overflows.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!redirect_ok && !halt && (fifo_free >= CW'(BURST_WORDS))) state_d = REQ;
      end
      REQ: begin
        if (accept)                          state_d = redirect_ok ? DRAIN : BURST;
        else if (redirect_ok || redirect_bad) state_d = IDLE;
      end
      BURST: begin
        if (last_beat)        state_d = IDLE;
        else if (redirect_ok) state_d = DRAIN;
      end
      DRAIN: begin
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_enable      = 1'b0;
    mem_address     = '0;
    mem_access_size = BURST_SIZE;
    mem_rw          = 1'b0;
    if (state_q == REQ) begin
      mem_enable  = 1'b1;
      mem_address = pc_q;
    end
    insn_valid = (fifo_count != '0);
    insn_pc    = fifo_pop_data[ENTRY_W-1:DATA_WIDTH];
    insn       = fifo_pop_data[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      lat_q  <= '0;
      beat_q <= '0;
    end else begin
      if (accept) begin
        lat_q  <= LAT_W'(READ_LATENCY - 1);
        beat_q <= '0;
      end else if (state_q inside {BURST, DRAIN}) begin
        if (lat_q != '0) lat_q  <= lat_q - 1'b1;
        else             beat_q <= beat_q + 1'b1;
      end
      if (redirect_ok)
        pc_q <= redirect_target;
      else if ((state_q == BURST) && last_beat)
        pc_q <= pc_q + ADDR_WIDTH'(4 * BURST_WORDS);
    end
  end

  always_comb begin
    fifo_push      = (state_q == BURST) && beat_now && !redirect_ok;
    fifo_pop       = insn_valid && insn_ready && !redirect_ok;
    fifo_push_data = {pc_q + (ADDR_WIDTH'(beat_q) << 2), mem_data};
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_ok),
    .push      (fifo_push),
    .push_data (fifo_push_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .count     (fifo_count),
    .free      (fifo_free)
  );

endmodule
